// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight register writes for DEPTH post-decode
// stages, selects forwarding sources per decode operand and raises load-use stalls.
module pipe_hazard_scoreboard #(
  parameter int NREG      = 16,
  parameter int DEPTH     = 3,
  parameter int NSRC      = 3,
  parameter int LOAD_LAT  = 2,
  parameter int NOFWD_REG = 15,
  localparam int RW = $clog2(NREG),
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 id_valid,
  input  logic [NSRC*RW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_use,
  input  logic [RW-1:0]        id_dst,
  input  logic                 id_dst_we,
  input  logic                 id_is_load,
  input  logic                 flush,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic                 stall,
  output logic                 pc_le,
  output logic                 ifid_le,
  output logic                 nop_insert,
  output logic                 issue,
  output logic [DEPTH-1:0]     stage_valid,
  output logic [15:0]          stall_count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [RW-1:0]    dst_q [DEPTH];
  logic [RW-1:0]    dst_d [DEPTH];
  logic [15:0]      cnt_q, cnt_d;

  logic [NSRC*SW-1:0] fwd_raw;
  logic [NSRC-1:0]    haz;
  logic               stall_raw;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_raw = '0;
    haz     = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (id_src_use[i] && v_q[k] &&
            (dst_q[k] == id_src[i*RW +: RW]) &&
            (id_src[i*RW +: RW] != RW'(NOFWD_REG))) begin
          fwd_raw[i*SW +: SW] = SW'(k + 1);
          haz[i]              = ld_q[k] && ((k + 1) < LOAD_LAT);
        end
      end
    end
  end

  assign stall_raw   = id_valid & ~flush & (|haz);

  // Reset low forces a quiet interface regardless of inputs.
  assign stall       = CLR & stall_raw;
  assign issue       = CLR & id_valid & ~flush & ~stall_raw;
  assign nop_insert  = ~CLR | stall_raw | flush | ~id_valid;
  assign fwd_sel     = CLR ? fwd_raw : '0;
  assign pc_le       = ~stall;
  assign ifid_le     = ~stall;
  assign stage_valid = v_q;
  assign stall_count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
    v_d[0]   = issue & id_dst_we;
    dst_d[0] = id_dst;
    ld_d[0]  = id_is_load;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]   = v_q[k-1];
      dst_d[k] = dst_q[k-1];
      ld_d[k]  = ld_q[k-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      v_q   <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k] <= dst_d[k];
      end
    end
  end

endmodule
